rsa_core: RTL and testbench
===========================

RSA_CORE -- requirements
Module: rsa_core

Interface
REQ-001 Parameter: WIDTH, 64, operand/modulus/exponent width in bits (≥8).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 key_we  in  1  key register write strobe.
REQ-005 key_sel  in  2  key select: 0=N, 1=e, 2=d; 3 reserved, write ignored.
REQ-006 key_data  in  WIDTH  key value written when key_we=1.
REQ-007 in_valid  in  1  request valid.
REQ-008 in_ready  out  1  core can accept a request.
REQ-009 in_mode  in  1  0=encrypt (exponent e), 1=decrypt (exponent d).
REQ-010 in_msg  in  WIDTH  message/ciphertext operand.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data  out  WIDTH  msg^exp mod N.
REQ-014 out_err  out  1  request rejected (operand invalid).
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, CHECK, MUL, SQR, DONE; in_ready=1 only in IDLE.
REQ-017 Request accepted on edge with in_valid&in_ready; in_msg, in_mode, and the selected exponent are captured; state→CHECK.
REQ-018 CHECK: if N<2 or msg≥N → out_err=1, out_data=0, state→DONE next edge; otherwise result=1, base=msg, state→MUL.
REQ-019 Algorithm: right-to-left binary; MUL runs result=result·base mod N if exponent LSB=1 (skipped in 0 cycles otherwise); SQR runs base=base·base mod N, then exponent>>=1.
REQ-020 After SQR, if shifted exponent=0 → DONE, else → MUL; exponent 0 at CHECK → DONE with out_data=1.
REQ-021 Each modular multiply occupies exactly WIDTH+1 cycles (1 start + WIDTH iterations).
REQ-022 Latency bound, accept to out_valid: ≤ 2 + (bitlen(exp)+popcount(exp))·(WIDTH+1) cycles.
REQ-023 DONE: out_valid=1, out_data/out_err stable until out_valid&out_ready edge, then → IDLE; out_valid, out_err cleared.
REQ-024 out_ready held low: core stalls in DONE indefinitely with no data change.
REQ-025 Multiply arithmetic: MSB-first interleaved shift-add, accumulator WIDTH+1 bits; per iteration acc=2·acc, conditional −N, conditional +a, conditional −N; acc<N invariant.
REQ-026 key_we honoured only in IDLE; ignored while busy=1 (in-flight keys unaffected either way since exponent/modulus are snapshot at accept).
REQ-027 key_we and in_valid on same IDLE edge: key write takes effect; request uses pre-write key values.
REQ-028 Exponent MSB set to 1 with WIDTH bits supported; no overflow of any internal register.

Reset
REQ-029 On rst low: state=IDLE; N, e, d, result, base, exponent=0; out_valid=0, out_data=0, out_err=0, busy=0; in_ready=1 after release.
REQ-030 Reset mid-operation aborts the request; no out_valid is produced for it.

Structure
REQ-031 Package rsa_pkg holds state enum, KEY_N/KEY_E/KEY_D constants, MODE_ENC/MODE_DEC constants.
REQ-032 One sub-module modmul #(WIDTH): start, a, b, n in; done pulse, p out; WIDTH+1-cycle latency; instantiated once and shared by MUL and SQR.

Verification
REQ-033 WIDTH=16; N=3233, e=17, d=2753; encrypt 65 → out_data=2790, out_err=0; decrypt 2790 → 65.
REQ-034 WIDTH=64; N=4275095120893583027, d=1567911045903664193; decrypt 992274341492776796 → 180691; encrypt 180691 with e=65537 → 992274341492776796.
REQ-035 WIDTH=16; N=3233, msg=3233 → out_err=1, out_data=0, out_valid 2 cycles after accept; N=1 any msg → out_err=1.
REQ-036 out_ready low 20 cycles in DONE → out_valid, out_data constant; in_ready=0 throughout; one transfer on release.
REQ-037 key_we N=0 during busy → ignored, result correct; rst pulse mid-multiply → all outputs 0, no out_valid, next request correct.
REQ-038 e=0 → out_data=1; e=1 → out_data=msg; back-to-back requests with out_ready=1 → each result matches a reference model.

Source files
------------

// File: rtl/rsa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_pkg : shared state encoding and key/mode constants for rsa_core |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SQR   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] KEY_N = 2'd0;
  localparam logic [1:0] KEY_E = 2'd1;
  localparam logic [1:0] KEY_D = 2'd2;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rsa_modmul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | modmul : MSB-first interleaved modular multiplier, p = a*b mod n     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module modmul #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH:0]   w_dbl, w_red1, w_add, w_red2, w_n;

  // Operand a must already be reduced below n so one subtract suffices per step.
  always_comb begin
    w_n    = {1'b0, n_q};
    w_dbl  = acc_q << 1;
    w_red1 = (w_dbl >= w_n) ? (w_dbl - w_n) : w_dbl;
    w_add  = b_q[WIDTH-1] ? (w_red1 + {1'b0, a_q}) : w_red1;
    w_red2 = (w_add >= w_n) ? (w_add - w_n) : w_add;

    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      acc_d = '0;
      a_d   = a;
      b_d   = b;
      n_d   = n;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = w_red2;
      b_d   = b_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == CW'(1));
  assign p    = w_red2[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/rsa_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_core : right-to-left binary modular exponentiation, msg^exp % N  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rsa_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [1:0]       key_sel,
  input  logic [WIDTH-1:0] key_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] key_n_q, key_n_d, key_e_q, key_e_d, key_d_q, key_d_d;
  logic [WIDTH-1:0] mod_q, mod_d, exp_q, exp_d, base_q, base_d, res_q, res_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic             pend_q, pend_d;

  logic             mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;

  modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (mod_q),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_comb begin
    state_d     = state_q;
    key_n_d     = key_n_q;
    key_e_d     = key_e_q;
    key_d_d     = key_d_q;
    mod_d       = mod_q;
    exp_d       = exp_q;
    base_d      = base_q;
    res_d       = res_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    pend_d      = pend_q;
    mm_start    = 1'b0;
    mm_a        = res_q;
    mm_b        = base_q;

    case (state_q)
      ST_IDLE: begin
        if (key_we) begin
          case (key_sel)
            KEY_N:   key_n_d = key_data;
            KEY_E:   key_e_d = key_data;
            KEY_D:   key_d_d = key_data;
            default: ;
          endcase
        end
        // Snapshot from the current registers so a same-edge key write is not seen.
        if (in_valid) begin
          mod_d   = key_n_q;
          exp_d   = (in_mode == MODE_DEC) ? key_d_q : key_e_q;
          base_d  = in_msg;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if ((mod_q < WIDTH'(2)) || (base_q >= mod_q)) begin
          out_err_d   = 1'b1;
          out_data_d  = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (exp_q == '0) begin
          out_data_d  = WIDTH'(1);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          res_d   = WIDTH'(1);
          state_d = exp_q[0] ? ST_MUL : ST_SQR;
        end
      end

      ST_MUL: begin
        if (!pend_q) begin
          mm_start = 1'b1;
          pend_d   = 1'b1;
        end else if (mm_done) begin
          res_d   = mm_p;
          pend_d  = 1'b0;
          state_d = ST_SQR;
        end
      end

      ST_SQR: begin
        mm_a = base_q;
        mm_b = base_q;
        if (!pend_q) begin
          mm_start = 1'b1;
          pend_d   = 1'b1;
        end else if (mm_done) begin
          base_d = mm_p;
          exp_d  = exp_q >> 1;
          pend_d = 1'b0;
          if (exp_q[WIDTH-1:1] == '0) begin
            out_data_d  = res_q;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = exp_q[1] ? ST_MUL : ST_SQR;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      key_n_q     <= '0;
      key_e_q     <= '0;
      key_d_q     <= '0;
      mod_q       <= '0;
      exp_q       <= '0;
      base_q      <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_n_q     <= key_n_d;
      key_e_q     <= key_e_d;
      key_d_q     <= key_d_d;
      mod_q       <= mod_d;
      exp_q       <= exp_d;
      base_q      <= base_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      pend_q      <= pend_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rsa_core : directed + randomized checks of rsa_core vs a modexp   |
// | reference model. Revision: 1.0                                      |
// +--------------------------------------------------------------------+
module tb_rsa_core;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        k_we, i_v, i_rdy, i_mode, o_v, o_rdy, o_err, bsy;
    logic [1:0]  k_sel;
    logic [63:0] k_data, i_msg, o_data;
    // 16-bit instance
    logic        s_we, s_v, s_rdy, s_mode, s_ov, s_ordy, s_err, s_bsy;
    logic [1:0]  s_sel;
    logic [15:0] s_data, s_msg, s_odata;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mN, mE, mD, last_data, rv, held;

    rsa_core #(.WIDTH(64)) u_dut (
        .clk(clk), .rst(rst), .key_we(k_we), .key_sel(k_sel), .key_data(k_data),
        .in_valid(i_v), .in_ready(i_rdy), .in_mode(i_mode), .in_msg(i_msg),
        .out_valid(o_v), .out_ready(o_rdy), .out_data(o_data), .out_err(o_err), .busy(bsy)
    );

    rsa_core #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst(rst), .key_we(s_we), .key_sel(s_sel), .key_data(s_data),
        .in_valid(s_v), .in_ready(s_rdy), .in_mode(s_mode), .in_msg(s_msg),
        .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_odata), .out_err(s_err), .busy(s_bsy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: square-and-multiply with wide plain arithmetic.
    function automatic logic [63:0] ref_pow(input logic [63:0] m, input logic [63:0] x,
                                            input logic [63:0] nn);
        logic [127:0] r, b;
        r = 128'd1 % nn;
        b = {64'd0, m};
        for (int i = 0; i < 64; i++) begin
            if (x[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[63:0];
    endfunction

    task automatic model_key(input logic [1:0] sel, input logic [63:0] val);
        case (sel)
            2'd0: mN = val;
            2'd1: mE = val;
            2'd2: mD = val;
            default: ;
        endcase
    endtask

    task automatic kw64(input logic [1:0] sel, input logic [63:0] val);
        k_we = 1'b1; k_sel = sel; k_data = val;
        @(posedge clk);
        @(negedge clk);
        k_we = 1'b0;
        model_key(sel, val);
    endtask

    task automatic kw16(input logic [1:0] sel, input logic [15:0] val);
        s_we = 1'b1; s_sel = sel; s_data = val;
        @(posedge clk);
        @(negedge clk);
        s_we = 1'b0;
    endtask

    task automatic req64(input logic mode, input logic [63:0] msg, input string tag,
                         input bit kw = 1'b0, input logic [1:0] ks = 2'd0,
                         input logic [63:0] kd = 64'd0, input int busy_kw = 0);
        logic [63:0] xp, expd;
        logic        eerr;
        int          lat, bound, bl, pc, wc;
        xp    = mode ? mD : mE;
        eerr  = (mN < 64'd2) || (msg >= mN);
        expd  = eerr ? 64'd0 : ref_pow(msg, xp, mN);
        bl = 0; pc = 0;
        for (int i = 0; i < 64; i++) if (xp[i]) begin bl = i + 1; pc++; end
        bound = 2 + (bl + pc) * 65;
        wc = 0;
        while (!i_rdy && wc < 100) begin @(negedge clk); wc++; end
        i_v = 1'b1; i_mode = mode; i_msg = msg;
        if (kw) begin k_we = 1'b1; k_sel = ks; k_data = kd; end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        i_v = 1'b0; k_we = 1'b0;
        if (kw) model_key(ks, kd);
        while (!o_v && lat < bound + 50) begin
            if (busy_kw != 0 && lat == busy_kw) begin k_we = 1'b1; k_sel = 2'd0; k_data = 64'd0; end
            @(posedge clk);
            lat++;
            @(negedge clk);
            k_we = 1'b0;
        end
        if (!o_v) $display("TIMEOUT %s waiting for out_valid after %0d cycles", tag, lat);
        chk($sformatf("%s_valid", tag), o_v, 1'b1);
        chk($sformatf("%s_latency(%0d)", tag, lat), (eerr ? (lat == 2) : (lat <= bound)), 1'b1);
        chk($sformatf("%s_data", tag), o_data, expd);
        chk($sformatf("%s_err", tag), o_err, eerr);
        last_data = o_data;
        if (o_rdy) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_valid_clr", tag), o_v, 1'b0);
        end
    endtask

    task automatic req16(input logic mode, input logic [15:0] msg, input logic [15:0] xp,
                         input logic [15:0] expd, input logic eerr, input string tag);
        int lat, bound, bl, pc;
        bl = 0; pc = 0;
        for (int i = 0; i < 16; i++) if (xp[i]) begin bl = i + 1; pc++; end
        bound = 2 + (bl + pc) * 17;
        s_v = 1'b1; s_mode = mode; s_msg = msg;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        s_v = 1'b0;
        while (!s_ov && lat < bound + 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!s_ov) $display("TIMEOUT %s waiting for out_valid after %0d cycles", tag, lat);
        chk($sformatf("%s_valid", tag), s_ov, 1'b1);
        chk($sformatf("%s_latency(%0d)", tag, lat), (eerr ? (lat == 2) : (lat <= bound)), 1'b1);
        chk($sformatf("%s_data", tag), s_odata, expd);
        chk($sformatf("%s_err", tag), s_err, eerr);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s_valid_clr", tag), s_ov, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        k_we = 1'b0; k_sel = 2'd0; k_data = 64'd0; i_v = 1'b0; i_mode = 1'b0; i_msg = 64'd0; o_rdy = 1'b1;
        s_we = 1'b0; s_sel = 2'd0; s_data = 16'd0; s_v = 1'b0; s_mode = 1'b0; s_msg = 16'd0; s_ordy = 1'b1;
        mN = 64'd0; mE = 64'd0; mD = 64'd0; last_data = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", o_v, 1'b0);
        chk("rst_out_data", o_data, 64'd0);
        chk("rst_out_err", o_err, 1'b0);
        chk("rst_busy", bsy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", i_rdy, 1'b1);
        chk("rst_busy16", s_bsy, 1'b0);

        // Textbook 16-bit key pair
        kw16(2'd0, 16'd3233); kw16(2'd1, 16'd17); kw16(2'd2, 16'd2753);
        req16(1'b0, 16'd65, 16'd17, 16'd2790, 1'b0, "w16_enc");
        req16(1'b1, 16'd2790, 16'd2753, 16'd65, 1'b0, "w16_dec");
        req16(1'b0, 16'd3233, 16'd17, 16'd0, 1'b1, "w16_msg_eq_n");
        kw16(2'd0, 16'd1);
        req16(1'b0, 16'd0, 16'd17, 16'd0, 1'b1, "w16_n_one");

        // 64-bit key pair
        kw64(2'd0, 64'd4275095120893583027);
        kw64(2'd1, 64'd65537);
        kw64(2'd2, 64'd1567911045903664193);
        req64(1'b1, 64'd992274341492776796, "w64_dec");
        chk("w64_dec_const", last_data, 64'd180691);
        req64(1'b0, 64'd180691, "w64_enc");
        chk("w64_enc_const", last_data, 64'd992274341492776796);
        req64(1'b0, mN, "w64_msg_eq_n");

        rv = {$urandom, $urandom} % mN;
        kw64(2'd1, 64'd0);
        req64(1'b0, rv, "exp_zero");
        chk("exp_zero_one", last_data, 64'd1);
        kw64(2'd1, 64'd1);
        req64(1'b0, rv, "exp_one");
        chk("exp_one_msg", last_data, rv);
        kw64(2'd3, 64'd5);
        req64(1'b0, rv, "sel3_ignored");
        chk("sel3_ignored_msg", last_data, rv);

        // Key write coincident with accept: request still sees e=1
        req64(1'b0, rv, "same_edge", 1'b1, 2'd1, 64'd3);
        chk("same_edge_old_e", last_data, rv);
        req64(1'b0, rv, "same_edge_new_e");

        // N=0 written mid-operation must be dropped
        req64(1'b0, rv, "busy_kw", 1'b0, 2'd0, 64'd0, 40);
        req64(1'b0, rv, "after_busy_kw");

        // Back-pressure hold in DONE
        o_rdy = 1'b0;
        req64(1'b1, rv, "stall");
        held = o_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", i), o_v, 1'b1);
            chk($sformatf("stall_data_%0d", i), o_data, held);
            chk($sformatf("stall_in_ready_%0d", i), i_rdy, 1'b0);
        end
        o_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_valid", o_v, 1'b0);
        chk("stall_release_ready", i_rdy, 1'b1);
        @(negedge clk);
        chk("stall_single_transfer", o_v, 1'b0);

        // Random full-width keys, exponent MSB forced on for encrypt
        for (int t = 0; t < 3; t++) begin
            kw64(2'd0, {1'b1, $urandom_range(32'h7fff_ffff, 0), $urandom});
            kw64(2'd1, {1'b1, $urandom_range(32'h7fff_ffff, 0), $urandom});
            kw64(2'd2, {$urandom, $urandom});
            rv = {$urandom, $urandom} % mN;
            req64(1'b0, rv, $sformatf("rand_enc_%0d", t));
            req64(1'b1, rv, $sformatf("rand_dec_%0d", t));
        end
        req64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "rand_msg_ge_n");

        // Asynchronous reset in the middle of a multiply
        kw64(2'd0, 64'd3233);
        kw64(2'd1, 64'hFFFF);
        i_v = 1'b1; i_mode = 1'b0; i_msg = 64'd5;
        @(posedge clk);
        @(negedge clk);
        i_v = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", o_v, 1'b0);
        chk("midrst_data", o_data, 64'd0);
        chk("midrst_err", o_err, 1'b0);
        chk("midrst_busy", bsy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mN = 64'd0; mE = 64'd0; mD = 64'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_valid_%0d", i), o_v, 1'b0);
        end
        kw64(2'd0, 64'd3233);
        kw64(2'd1, 64'd17);
        req64(1'b0, 64'd65, "post_reset");
        chk("post_reset_const", last_data, 64'd2790);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
